bitty_sequencer: RTL
====================

# bitty_sequencer

Instruction sequencer for the bitty core. Fetches 16-bit instructions from a synchronous instruction memory, presents each to the core with `run` held high until the core's `done` pulse, then advances a program counter. Supports a programmable start/last address window, optional looping, stop requests and a done-timeout error. Sits between instruction memory and `bitty_core`; it is the only driver of the core's `run` and `instruction` inputs.

## Interface
- ADDR_W, 8: instruction memory address width
- TIMEOUT, 15: max EXEC cycles without `done` before error (1..255)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins execution at `start_addr` (accepted in IDLE or ERROR only)
- stop  in  1  pulse; halt after the current instruction completes
- loop  in  1  1: wrap to `start_addr` after `last_addr`; 0: halt
- start_addr  in  ADDR_W  first instruction address, latched on accepted `start`
- last_addr  in  ADDR_W  final instruction address, latched on accepted `start`
- mem_addr  out  ADDR_W  instruction memory address, always equals `pc`
- mem_rd  out  1  memory read strobe
- mem_rdata  in  16  read data, valid the cycle after `mem_rd`
- instruction  out  16  held instruction to core
- run  out  1  core run enable
- done  in  1  single-cycle completion pulse from core
- pc  out  ADDR_W  current program counter
- busy  out  1  high in FETCH, LOAD, EXEC
- finished  out  1  one-cycle pulse on normal halt
- error  out  1  sticky timeout flag
- instr_count  out  16  retired instructions, saturating

## Operation
- States: IDLE, FETCH, LOAD, EXEC, ERROR.
- IDLE: outputs quiet. `start`=1 -> latch `start_addr`, `last_addr`, `loop`; pc<=start_addr; instr_count<=0; clear stop_pending -> FETCH.
- FETCH: mem_rd=1 for exactly this cycle -> LOAD.
- LOAD: instruction<=mem_rdata at end of cycle; timeout counter<=0 -> EXEC.
- EXEC: run=1, `instruction` stable. Counter increments each cycle `done`=0.
  - done=1: instr_count+1 (hold at 16'hFFFF); run drops next cycle.
    - stop_pending=1 -> IDLE, finished pulse.
    - pc==last_addr, loop=1 -> pc<=start_addr, FETCH.
    - pc==last_addr, loop=0 -> IDLE, finished pulse.
    - else pc<=pc+1 (mod 2^ADDR_W, wraps FF->00 for ADDR_W=8) -> FETCH.
  - counter reaches TIMEOUT with done=0 -> ERROR.
- ERROR: run=0, error=1, busy=0. `start` clears error and behaves as IDLE start. `stop` ignored.
- `stop` while busy sets stop_pending; ignored in IDLE/ERROR. `start` while busy ignored.
- `start` and `stop` same cycle in IDLE: start taken, stop dropped.
- `stop` and `done` same cycle in EXEC: current instruction retires, then IDLE with finished pulse.
- `done` outside EXEC ignored.

## Timing
- Reset (async, any state): state IDLE; pc, mem_addr, instruction, instr_count = 0; mem_rd, run, busy, finished, error = 0; stop_pending = 0; latched addresses 0, loop 0.
- `start` at edge N: FETCH in cycle N+1, LOAD N+2, run high from N+3.
- Per instruction: 2 cycles overhead + EXEC cycles through `done`; bitty core (3-cycle) gives 5 cycles/instruction.
- pc update and new FETCH occur in the cycle after `done`.
- finished asserted exactly one cycle, the first IDLE cycle.
- Timeout: ERROR entered TIMEOUT cycles after EXEC entry if no `done`.
- Reset during EXEC drops `run` immediately (asynchronously).

## Test plan
- start_addr=0x10, last_addr=0x12, loop=0, memory 0x10..0x12 = A001/B002/C003, core done 3 cycles after run -> three FETCHes at 0x10,0x11,0x12, instruction matches each word while run=1, finished pulse, instr_count=3, pc=0x12.
- Same window, loop=1, stop pulsed during the 5th EXEC -> addresses 10,11,12,10,11, halt after 5th done, instr_count=5, finished pulse.
- start_addr=0xFE, last_addr=0x01, loop=0 -> pc sequence FE,FF,00,01, then IDLE.
- Core never asserts done, TIMEOUT=15 -> run high 15 cycles, then error=1, run=0; start pulse clears error and refetches start_addr.
- start and stop same cycle in IDLE -> execution starts; start pulsed while busy -> ignored, pc unchanged.
- Assert reset mid-EXEC -> run, busy, pc, instr_count zero immediately; no finished pulse.

Source files
------------

// File: rtl/bitty_sequencer.sv
// Instruction sequencer for the bitty core. It fetches each word, holds it
// on `instruction` with `run` high until `done`, then advances through the window.
module bitty_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EXEC  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] first_addr_reg;
  logic [ADDR_W-1:0] final_addr_reg;
  logic              loop_reg;
  logic [15:0]       instr_reg;
  logic [15:0]       count_reg;
  logic [7:0]        tcnt_reg;
  logic              stop_pending_reg;
  logic              finished_reg;

  logic accept_start;
  logic retire;
  logic halt_req;
  logic at_last;
  logic timeout_hit;

  assign accept_start = ((state_reg == IDLE) || (state_reg == ERROR)) && start;
  assign retire       = (state_reg == EXEC) && done;
  // A stop arriving together with done still counts as a halt request.
  assign halt_req     = stop_pending_reg || stop;
  assign at_last      = (pc_reg == final_addr_reg);
  assign timeout_hit  = (state_reg == EXEC) && !done && (tcnt_reg == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ERROR: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: state_next = LOAD;
      LOAD:  state_next = EXEC;
      EXEC: begin
        if (done) begin
          if (halt_req || (at_last && !loop_reg)) begin
            state_next = IDLE;
          end else begin
            state_next = FETCH;
          end
        end else if (timeout_hit) begin
          state_next = ERROR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from the state register so reset drops run at once.
  always_comb begin
    mem_rd = 1'b0;
    run    = 1'b0;
    busy   = 1'b0;
    error  = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
      end
      LOAD: begin
        busy = 1'b1;
      end
      EXEC: begin
        run  = 1'b1;
        busy = 1'b1;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: begin
        mem_rd = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg           <= '0;
      first_addr_reg   <= '0;
      final_addr_reg   <= '0;
      loop_reg         <= 1'b0;
      instr_reg        <= '0;
      count_reg        <= '0;
      tcnt_reg         <= '0;
      stop_pending_reg <= 1'b0;
      finished_reg     <= 1'b0;
    end else begin
      finished_reg <= 1'b0;

      if (accept_start) begin
        first_addr_reg   <= start_addr;
        final_addr_reg   <= last_addr;
        loop_reg         <= loop;
        pc_reg           <= start_addr;
        count_reg        <= '0;
        stop_pending_reg <= 1'b0;
      end else if (busy && stop) begin
        stop_pending_reg <= 1'b1;
      end

      if (state_reg == LOAD) begin
        instr_reg <= mem_rdata;
        tcnt_reg  <= '0;
      end

      if ((state_reg == EXEC) && !done) begin
        tcnt_reg <= tcnt_reg + 8'd1;
      end

      if (retire) begin
        if (count_reg != 16'hFFFF) begin
          count_reg <= count_reg + 16'd1;
        end
        if (state_next == IDLE) begin
          finished_reg     <= 1'b1;
          stop_pending_reg <= 1'b0;
        end else if (at_last) begin
          pc_reg <= first_addr_reg;
        end else begin
          pc_reg <= pc_reg + 1'b1;
        end
      end
    end
  end

  assign mem_addr    = pc_reg;
  assign pc          = pc_reg;
  assign instruction = instr_reg;
  assign instr_count = count_reg;
  assign finished    = finished_reg;

endmodule
